// File: rtl/pcie_wrap0_st_pkg.sv
// Shared definitions for the PCIe wrapper Avalon-ST adapters.
// Payload layout (LSB first): data, channel, eop, sop.
package pcie_wrap0_st_pkg;

    localparam int IN_RL_MAX = 4;
    localparam int DATA_OFS  = 0;

    function automatic int chan_ofs(input int data_w);
        return data_w;
    endfunction

    function automatic int eop_ofs(input int data_w, input int chan_w);
        return data_w + chan_w;
    endfunction

    function automatic int sop_ofs(input int data_w, input int chan_w);
        return data_w + chan_w + 1;
    endfunction

    function automatic int payload_w(input int data_w, input int chan_w);
        return data_w + chan_w + 2;
    endfunction

endpackage

// File: rtl/pcie_wrap0_st_sc_fifo.sv
// Single-clock show-ahead FIFO.
// Ports: push/push_data write a word when there is room or a pop happens in
// the same cycle; pop retires the head; head_data is the current head (0 when
// empty); fill_level is the occupancy 0..2**ADDR_W.
module pcie_wrap0_st_sc_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head_data,
    output logic [ADDR_W:0]   fill_level
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop && (fill_level != '0);
    // When full, a write is still allowed if the head leaves in the same
    // cycle: the slot being written is the one being vacated.
    assign push_ok = push && ((fill_level != FULL) || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end

    // Storage is not reset; gating on occupancy keeps the head at 0 when empty.
    assign head_data = (fill_level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/pcie_wrap0_st_rl_adapter.sv
// Avalon-ST ready-latency adapter: upstream ready latency IN_RL, downstream 0.
// Ports: in_* upstream beat (pushed whenever in_valid), in_ready advertises
// room for IN_RL more beats; out_* FIFO head with out_ready accept;
// fill_level occupancy; overflow sticky drop flag, cleared by clear_overflow.
module pcie_wrap0_st_rl_adapter
    import pcie_wrap0_st_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CHAN_W = 1,
    parameter int IN_RL  = 1,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHAN_W-1:0] in_channel,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CHAN_W-1:0] out_channel,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    input  logic              out_ready,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow,
    input  logic              clear_overflow
);
    localparam int DEPTH  = 2**ADDR_W;
    localparam int PW     = payload_w(DATA_W, CHAN_W);
    localparam int CH_OFS = chan_ofs(DATA_W);
    localparam int EO_OFS = eop_ofs(DATA_W, CHAN_W);
    localparam int SO_OFS = sop_ofs(DATA_W, CHAN_W);
    localparam logic [ADDR_W:0] FULL   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] THRESH = (ADDR_W+1)'(DEPTH - IN_RL);

    if (DEPTH < 2*IN_RL + 2 || IN_RL > IN_RL_MAX || IN_RL < 0 || CHAN_W < 1) begin : g_bad_cfg
        $error("pcie_wrap0_st_rl_adapter: illegal IN_RL/ADDR_W/CHAN_W combination");
    end

    logic [PW-1:0] in_payload;
    logic [PW-1:0] head;
    logic          pop;
    logic          drop;
    logic          ready_en;

    assign in_payload = {in_startofpacket, in_endofpacket, in_channel, in_data};
    assign pop        = out_valid && out_ready;
    assign drop       = in_valid && (fill_level == FULL) && !pop;

    pcie_wrap0_st_sc_fifo #(
        .WIDTH  (PW),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .push       (in_valid),
        .push_data  (in_payload),
        .pop        (pop),
        .head_data  (head),
        .fill_level (fill_level)
    );

    // Holds in_ready low while in reset and for the first cycle after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    assign in_ready          = ready_en && (fill_level < THRESH);
    assign out_valid         = (fill_level != '0);
    assign out_data          = head[DATA_OFS +: DATA_W];
    assign out_channel       = head[CH_OFS +: CHAN_W];
    assign out_endofpacket   = head[EO_OFS];
    assign out_startofpacket = head[SO_OFS];

endmodule

// File: tb/tb_pcie_wrap0_st_rl_adapter.sv
module tb_pcie_wrap0_st_rl_adapter;
    localparam int DATA_W = 8;
    localparam int CHAN_W = 1;
    localparam int IN_RL  = 2;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int PW     = DATA_W + CHAN_W + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CHAN_W-1:0] in_channel;
    logic              in_sop;
    logic              in_eop;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CHAN_W-1:0] out_channel;
    logic              out_sop;
    logic              out_eop;
    logic              out_ready;
    logic [ADDR_W:0]   fill_level;
    logic              overflow;
    logic              clear_overflow;

    pcie_wrap0_st_rl_adapter #(
        .DATA_W (DATA_W),
        .CHAN_W (CHAN_W),
        .IN_RL  (IN_RL),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_channel        (in_channel),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_ready         (out_ready),
        .fill_level        (fill_level),
        .overflow          (overflow),
        .clear_overflow    (clear_overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of packed beats plus a sticky flag.
    logic [PW-1:0] mq [$];
    bit m_ovf;
    bit m_started;
    bit m_pop;
    bit m_acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_started = 1'b0;
        end else begin
            m_pop = (mq.size() != 0) && out_ready;
            m_acc = in_valid && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back({in_sop, in_eop, in_channel, in_data});
            if (in_valid && !m_acc) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
            m_started = 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en && !reset) begin
                chk("model_in_ready", in_ready, m_started && (mq.size() < DEPTH - IN_RL));
                chk("model_out_valid", out_valid, mq.size() != 0);
                chk("model_fill", fill_level, mq.size());
                chk("model_overflow", overflow, m_ovf);
                if (mq.size() != 0)
                    chk("model_head", {out_sop, out_eop, out_channel, out_data}, mq[0]);
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit ordy,
                       input bit clr = 1'b0, input bit sop = 1'b0,
                       input bit eop = 1'b0, input bit ch = 1'b0);
        @(negedge clk);
        in_valid       = v;
        in_data        = d;
        out_ready      = ordy;
        clear_overflow = clr;
        in_sop         = sop;
        in_eop         = eop;
        in_channel     = ch;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_channel = '0; in_sop = 1'b0; in_eop = 1'b0;
        out_ready = 1'b0; clear_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_data", out_data, 0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        chk("release_in_ready_high", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_fill", fill_level, 0);
        chk_en = 1'b1;

        // Back-to-back stream, sink always ready: each beat is the head right after its edge.
        for (int k = 0; k < 100; k++) begin
            cyc(1'b1, 8'(k), 1'b1, 1'b0, (k % 10) == 0, (k % 10) == 9, k[0]);
            chk("b2b_data", out_data, k);
            chk("b2b_valid", out_valid, 1);
        end
        chk("b2b_fill", fill_level, 1);
        chk("b2b_overflow", overflow, 0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("b2b_drained", out_valid, 0);

        // Compliant fill with the sink stalled.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 8'(8'h10 + k), 1'b0);
            if (k == 4) chk("fill5_in_ready", in_ready, 1);
            if (k == 5) begin
                chk("fill6_level", fill_level, 6);
                chk("fill6_in_ready", in_ready, 0);
            end
        end
        chk("fill8_level", fill_level, 8);
        chk("fill8_overflow", overflow, 0);

        // Non-compliant beat into a full FIFO, then sticky/clear behaviour.
        cyc(1'b1, 8'hEE, 1'b0);
        chk("drop_overflow", overflow, 1);
        chk("drop_fill", fill_level, 8);
        cyc(1'b0, 8'h00, 1'b0);
        chk("sticky_overflow", overflow, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clear_overflow", overflow, 0);
        cyc(1'b1, 8'hEF, 1'b0, 1'b1);
        chk("set_beats_clear", overflow, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clear_again", overflow, 0);
        chk("head_after_drops", out_data, 8'h10);

        // Full FIFO with simultaneous push and pop.
        cyc(1'b1, 8'hAA, 1'b1);
        chk("full_pp_fill", fill_level, 8);
        chk("full_pp_head", out_data, 8'h11);
        for (int i = 1; i < 7; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_order", out_data, 8'h11 + i);
        end
        cyc(1'b0, 8'h00, 1'b1);
        chk("drain_new_beat", out_data, 8'hAA);
        chk("drain_new_fill", fill_level, 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("drain_empty", out_valid, 0);

        // Reset in the middle of a partly filled FIFO.
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h30 + k), 1'b0);
        chk("pre_reset_fill", fill_level, 5);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_fill", fill_level, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_out_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 8'h55, 1'b0);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 8'h55);
        chk("post_rst_fill", fill_level, 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_empty", out_valid, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcie_wrap0_st_rl_adapter.md
# pcie_wrap0_st_rl_adapter

Parametrised Avalon-ST timing adapter for the PCIe wrapper that bridges an upstream source with ready latency `IN_RL` to a downstream sink with ready latency 0. Unlike the pass-through adapter, it honours backpressure through an internal show-ahead FIFO. It carries data, channel and packet delimiters, and reports occupancy and sticky overflow. It sits between the PCIe master bridge streams and downstream AFU-side consumers.

## Interface
- `DATA_W`, 8: data width in bits.
- `CHAN_W`, 1: channel width; minimum 1.
- `IN_RL`, 1: upstream ready latency; range 0..4.
- `ADDR_W`, 3: FIFO address width; `DEPTH = 2**ADDR_W`; requires `DEPTH >= 2*IN_RL+2`.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_data`  in  DATA_W  upstream data.
- `in_channel`  in  CHAN_W  upstream channel.
- `in_startofpacket`  in  1  SOP.
- `in_endofpacket`  in  1  EOP.
- `in_ready`  out  1  space available; beats may arrive up to `IN_RL` cycles later.
- `out_valid`  out  1  FIFO head valid.
- `out_data`, `out_channel`, `out_startofpacket`, `out_endofpacket`  out  per input  FIFO head payload.
- `out_ready`  in  1  downstream accept, ready latency 0.
- `fill_level`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a beat is dropped.
- `clear_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Payload is packed as `{sop, eop, channel, data}`, width `PAYLOAD_W = DATA_W+CHAN_W+2`.
- Push occurs when `in_valid` is high; `in_ready` is not sampled on the input side, which is the upstream's contract under `IN_RL`.
- Pop occurs when `out_valid && out_ready`.
- A push is written if `fill_level < DEPTH` or a pop happens in the same cycle. Otherwise the beat is dropped and `overflow` is set.
- `in_ready = (fill_level < DEPTH-IN_RL)`, combinational from the registered count. This guarantees no overflow for any compliant source.
- `out_valid = (fill_level != 0)`. Head payload comes from registered storage (show-ahead).
- On simultaneous push and pop, `fill_level` is unchanged and pointers advance independently.
- Pointers wrap modulo `DEPTH`. `fill_level` is kept as a separate `ADDR_W+1` counter, so full and empty are unambiguous.
- Packets are not checked; SOP/EOP pass through unmodified.
- Priority on `overflow`: a set in the same cycle as `clear_overflow` wins (stays 1).

## Timing
- Reset values:
  - `in_ready=0`, `out_valid=0`, `fill_level=0`, `overflow=0`.
  - Pointers are 0.
  - `out_*` payload is 0.
- `in_ready` rises in the first cycle after reset deassertion.
- A beat pushed at edge t is visible on `out_*` with `out_valid=1` after edge t (1-cycle latency), when the FIFO was empty.
- Sustained throughput is 1 beat/cycle when `out_ready` is held high, for any legal `IN_RL`.
- `in_ready` deasserts in the same cycle `fill_level` reaches `DEPTH-IN_RL`. Up to `IN_RL` further beats remain absorbable.
- Reset asserted mid-stream:
  - All state clears immediately (asynchronous), and in-flight beats are discarded.
  - No output glitches beyond the reset values.
- Payload storage needs no reset; only control registers and the output payload mux are reset.

## Structure
- Shared package `pcie_wrap0_st_pkg` holds:
  - the payload field offsets (SOP/EOP/channel/data), and the `PAYLOAD_W` function;
  - the `IN_RL` legal-range constant `IN_RL_MAX=4`.
- Sub-module `pcie_wrap0_st_sc_fifo`: single-clock show-ahead FIFO with `WIDTH`/`ADDR_W` parameters that outputs `fill_level`.
- The top level adds the ready-latency threshold, overflow logic and payload packing.
- Elaboration-time check: error if `DEPTH < 2*IN_RL+2` or `IN_RL > 4`.

## Test plan
- Reset, then idle: `in_ready` goes 0→1 one cycle after release; `out_valid=0`, `fill_level=0`.
- `IN_RL=2`, `DEPTH=8`, `out_ready=1`, 100 back-to-back beats with data 0..99: output order is 0..99, one per cycle, latency 1, `overflow=0`.
- `out_ready=0`, source compliant with `IN_RL=2`:
  - `in_ready` drops at `fill_level=6`;
  - the two in-flight beats are stored, giving `fill_level=8`;
  - `overflow` stays 0.
- Full FIFO with a forced non-compliant extra beat: the beat is dropped and `overflow=1` stays sticky. `clear_overflow` clears it, except when asserted together with a new drop, in which case it stays 1.
- Full FIFO with simultaneous push and pop: `fill_level` stays 8 and the pushed beat appears after the 7 older beats.
- Reset asserted with `fill_level=5`: all outputs return to reset values asynchronously, and the next beat after release emerges first.
